fetch_redirect_ctrl: RTL



---
 rtl/tspp_types_pkg.sv | 19 +
 rtl/redirect_prio_enc.sv | 27 ++
 rtl/fetch_redirect_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tspp_types_pkg.sv
// Shared types for the fetch redirect path: controller state encoding, machine word
// and the target alignment helper.
package tspp_types_pkg;

   localparam int unsigned WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      FLUSH   = 2'd2
   } redirect_state_t;

   function automatic logic addr_misaligned(input logic [1:0] addr_lo);
      return (addr_lo != 2'b00);
   endfunction

endpackage

// File: rtl/redirect_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins and is reported
// both as a binary index and as a one-hot grant.
module redirect_prio_enc #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o,
   output logic [N-1:0]     grant_o
);

   // Scan from lowest priority upward so the last hit is the highest-priority source.
   always_comb begin
      idx_o   = '0;
      grant_o = '0;
      valid_o = |req_i;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o      = IDX_W'(i);
            grant_o    = '0;
            grant_o[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Arbitrates redirect sources, holds the winning target until fetch accepts it and
// then flushes for FLUSH_CYCLES cycles. REDIRECT_MISALIGN_EN adds the target alignment check.
module fetch_redirect_ctrl #(
   parameter int unsigned NUM_SRC      = 4,
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NUM_SRC-1:0]          src_req_i,
   input  logic [NUM_SRC*ADDR_W-1:0]   src_addr_i,
   output logic [NUM_SRC-1:0]          src_ack_o,
   input  logic                        stall_req_i,
   input  logic                        fetch_busy_i,
   output logic                        update_pc_o,
   output logic [ADDR_W-1:0]           update_addr_o,
   output logic [$clog2(NUM_SRC)-1:0]  redirect_src_o,
   output logic                        flush_o,
   output logic                        stall_o
`ifdef REDIRECT_MISALIGN_EN
   ,
   output logic                        misalign_fault_o
`endif
);

   import tspp_types_pkg::*;

   localparam int unsigned IDX_W = $clog2(NUM_SRC);
   localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   redirect_state_t    state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [IDX_W-1:0]   src_q, src_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [NUM_SRC-1:0] higher_mask_s;
   logic [NUM_SRC-1:0] enc_req_s;
   logic [NUM_SRC-1:0] enc_grant_s;
   logic [IDX_W-1:0]   enc_idx_s;
   logic               enc_valid_s;
   logic               misalign_s;
   logic               update_pc_s;

   // Sources strictly ahead of the latched one may pre-empt it.
   always_comb begin
      higher_mask_s = '0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         higher_mask_s[i] = (IDX_W'(i) < src_q);
      end
   end

`ifdef REDIRECT_MISALIGN_EN
   assign misalign_s = (state_q == PENDING) && addr_misaligned(addr_q[1:0]);
`else
   assign misalign_s = 1'b0;
`endif

   // One encoder serves both fresh selection in IDLE and pre-emption while fetch is busy.
   always_comb begin
      enc_req_s = '0;
      if (state_q == IDLE) begin
         enc_req_s = src_req_i;
      end else if ((state_q == PENDING) && fetch_busy_i && !misalign_s) begin
         enc_req_s = src_req_i & higher_mask_s;
      end else begin
         enc_req_s = '0;
      end
   end

   redirect_prio_enc #(
      .N     (NUM_SRC),
      .IDX_W (IDX_W)
   ) u_prio_enc (
      .req_i   (enc_req_s),
      .idx_o   (enc_idx_s),
      .valid_o (enc_valid_s),
      .grant_o (enc_grant_s)
   );

   // Next-state logic; a commit always wins over a newly arriving request.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      src_d       = src_q;
      cnt_d       = cnt_q;
      update_pc_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (enc_valid_s) begin
               addr_d  = src_addr_i[enc_idx_s*ADDR_W +: ADDR_W];
               src_d   = enc_idx_s;
               state_d = PENDING;
            end else begin
               state_d = IDLE;
            end
         end
         PENDING: begin
            if (misalign_s) begin
               state_d = IDLE;
            end else if (!fetch_busy_i) begin
               update_pc_s = 1'b1;
               if (FLUSH_CYCLES == 1) begin
                  state_d = IDLE;
               end else begin
                  state_d = FLUSH;
                  cnt_d   = CNT_LOAD;
               end
            end else if (enc_valid_s) begin
               addr_d = src_addr_i[enc_idx_s*ADDR_W +: ADDR_W];
               src_d  = enc_idx_s;
            end else begin
               state_d = PENDING;
            end
         end
         FLUSH: begin
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State, latched target and flush counter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         src_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         src_q   <= src_d;
         cnt_q   <= cnt_d;
      end
   end

   assign src_ack_o      = enc_grant_s;
   assign update_pc_o    = update_pc_s;
   assign update_addr_o  = addr_q;
   assign redirect_src_o = src_q;
   assign flush_o        = (state_q != IDLE);
   assign stall_o        = stall_req_i | (state_q == PENDING);
`ifdef REDIRECT_MISALIGN_EN
   assign misalign_fault_o = misalign_s;
`endif

endmodule
